// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used by the fetch unit: widths, opcodes and the
// fetch-buffer entry layout.
package rv32_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned ILEN       = 32;
    localparam int unsigned OPC_W      = 7;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned FIFO_CNT_W = 2;

    localparam logic [OPC_W-1:0] J_JAL = 7'b1101111;

    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] PC_STEP       = 32'd4;

    // One decoded-stage entry: fetch address plus the instruction word
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    // J-type immediate from instruction bits [31:12]
    function automatic logic [XLEN-1:0] jal_imm(input logic [19:0] upper);
        return {{12{upper[19]}}, upper[7:0], upper[8], upper[18:9], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO with synchronous flush; head is always visible on pop_data.
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [WIDTH-1:0]      mem_q [FIFO_DEPTH];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [FIFO_CNT_W-1:0] count_q;
    logic                  do_pop;
    logic                  do_push;

    // A pop frees the slot the push may land in, so full+pop+push is legal
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);

    // Storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, in-flight address queue,
// two-entry output buffer, redirect flush with stale-response dropping.
// Optional build macro JAL_PREDECODE_EN: redirect on predecoded JAL responses.
module fetch_unit
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [ILEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
);

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);
    localparam int unsigned USE_W   = FIFO_CNT_W + 1;

    logic [XLEN-1:0]       pc_q;
    logic [FIFO_CNT_W-1:0] drop_q;
    logic [FIFO_CNT_W-1:0] aq_count;
    logic [FIFO_CNT_W-1:0] ob_count;
    logic [XLEN-1:0]       aq_head;
    logic [ENTRY_W-1:0]    ob_head_bits;
    fetch_entry_t          ob_head;
    fetch_entry_t          ob_push_data;
    logic [USE_W-1:0]      in_use_c;
    logic                  credit_free_c;
    logic                  rsp_fire_c;
    logic                  rsp_keep_c;
    logic                  pop_c;
    logic                  req_fire_c;
    logic                  jal_hit_c;
    logic [XLEN-1:0]       jal_target_c;

    // Responses only count when something is in flight; stale ones are dropped
    assign rsp_fire_c = imem_rsp_valid && (aq_count != '0);
    assign rsp_keep_c = rsp_fire_c && !redirect_valid && (drop_q == '0);
    assign pop_c      = if_valid && if_ready;

`ifdef JAL_PREDECODE_EN
    // Kept JAL responses steer fetch to their target (external redirect wins)
    assign jal_hit_c    = rsp_keep_c && (imem_rsp_data[OPC_W-1:0] == J_JAL);
    assign jal_target_c = aq_head + jal_imm(imem_rsp_data[31:12]);
`else
    assign jal_hit_c    = 1'b0;
    assign jal_target_c = aq_head;
`endif

    // Credit check on registered counts; a same-cycle pop frees one slot
    assign in_use_c      = USE_W'(aq_count) + USE_W'(ob_count) - USE_W'(pop_c);
    assign credit_free_c = (in_use_c < USE_W'(2));

    assign imem_req_valid = !rst && credit_free_c && !redirect_valid && !jal_hit_c;
    assign imem_req_addr  = pc_q;
    assign req_fire_c     = imem_req_valid && imem_req_ready;

    // Fetch pc and stale-response drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            drop_q <= '0;
        end else if (redirect_valid) begin
            pc_q   <= redirect_pc & PC_ALIGN_MASK;
            drop_q <= aq_count - FIFO_CNT_W'(rsp_fire_c);
        end else if (jal_hit_c) begin
            pc_q   <= jal_target_c & PC_ALIGN_MASK;
            drop_q <= aq_count - FIFO_CNT_W'(1);
        end else begin
            if (req_fire_c) begin
                pc_q <= pc_q + PC_STEP;
            end
            if (rsp_fire_c && (drop_q != '0)) begin
                drop_q <= drop_q - FIFO_CNT_W'(1);
            end
        end
    end

    // Addresses of accepted requests, retired in order by responses
    fetch_fifo #(
        .WIDTH (XLEN)
    ) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (1'b0),
        .push      (req_fire_c),
        .push_data (pc_q),
        .pop       (rsp_fire_c),
        .pop_data  (aq_head),
        .count     (aq_count)
    );

    assign ob_push_data.pc    = aq_head;
    assign ob_push_data.instr = imem_rsp_data;

    // Instructions waiting for decode
    fetch_fifo #(
        .WIDTH (ENTRY_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep_c),
        .push_data (ob_push_data),
        .pop       (pop_c),
        .pop_data  (ob_head_bits),
        .count     (ob_count)
    );

    assign ob_head  = fetch_entry_t'(ob_head_bits);
    assign if_valid = (ob_count != '0);
    assign if_instr = ob_head.instr;
    assign if_pc    = ob_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit with a small in-order memory model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem_q[$];
    logic [31:0] acc_log[$];
    int          acc_cnt;
    logic        mem_hold;
    logic        spurious;
    logic        rsp_from_q;

    fetch_unit #(
        .RESET_PC (TB_RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
`ifdef JAL_PREDECODE_EN
        if (a == 32'h0000_0020) return 32'h0100_006F;
`endif
        return {a[23:0], 8'h13};
    endfunction

    task automatic to_neg();
        @(negedge clk);
    endtask

    // Sample acceptance before the edge, then drive the memory response
    task automatic to_pos();
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            mem_q.delete();
            rsp_from_q     = 1'b0;
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
            return;
        end
        if (rsp_from_q) void'(mem_q.pop_front());
        if (acc) begin
            mem_q.push_back(a);
            acc_log.push_back(a);
            acc_cnt++;
        end
        rsp_from_q     = !mem_hold && (mem_q.size() > 0);
        imem_rsp_valid = rsp_from_q || spurious;
        imem_rsp_data  = rsp_from_q ? mem_word(mem_q[0]) : 32'hDEAD_0013;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        mem_hold       = 1'b0;
        spurious       = 1'b0;
        to_neg(); to_pos(); to_neg(); to_pos();
        rst = 1'b0;
        acc_log.delete();
        acc_cnt = 0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b1;
        mem_hold       = 1'b0;
        spurious       = 1'b0;
        rsp_from_q     = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        acc_cnt        = 0;
        to_neg();
        n_checks++;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
        n_checks++;
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %b expected 0", if_valid); end
        n_checks++;
        if (if_instr !== 32'h0) begin n_fail++; $display("FAIL reset_if_instr: got %h expected 0", if_instr); end
        n_checks++;
        if (if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_if_pc: got %h expected 0", if_pc); end
        n_checks++;
        if (imem_req_addr !== TB_RESET_PC) begin n_fail++; $display("FAIL reset_req_addr: got %h expected %h", imem_req_addr, TB_RESET_PC); end
        to_pos();
    endtask

    task automatic test_stream();
        do_reset();
        for (int n = 0; n < 10; n++) begin
            to_neg();
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'(4 * n)) begin
                n_fail++; $display("FAIL stream_req cyc%0d: got v=%b a=%h expected v=1 a=%h", n, imem_req_valid, imem_req_addr, 32'(4 * n));
            end
            if (n < 2) begin
                n_checks++;
                if (if_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid cyc%0d: got %b expected 0", n, if_valid); end
            end else begin
                n_checks++;
                if (if_valid !== 1'b1 || if_pc !== 32'(4 * (n - 2)) || if_instr !== mem_word(32'(4 * (n - 2)))) begin
                    n_fail++; $display("FAIL stream_if cyc%0d: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h", n, if_valid, if_pc, if_instr, 32'(4 * (n - 2)), mem_word(32'(4 * (n - 2))));
                end
            end
            to_pos();
        end
    endtask

    task automatic test_spurious_rsp();
        do_reset();
        imem_req_ready = 1'b0;
        spurious       = 1'b1;
        for (int n = 0; n < 4; n++) begin
            to_neg();
            n_checks++;
            if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== TB_RESET_PC) begin
                n_fail++; $display("FAIL spurious_idle cyc%0d: got if_v=%b req_v=%b a=%h expected 0 1 %h", n, if_valid, imem_req_valid, imem_req_addr, TB_RESET_PC);
            end
            to_pos();
        end
        imem_req_ready = 1'b1;
        spurious       = 1'b0;
        for (int n = 0; n < 3; n++) begin
            to_neg();
            n_checks++;
            if (n < 2) begin
                if (if_valid !== 1'b0) begin n_fail++; $display("FAIL spurious_leak cyc%0d: got %b expected 0", n, if_valid); end
            end else begin
                if (if_valid !== 1'b1 || if_pc !== TB_RESET_PC || if_instr !== 32'h0000_0013) begin
                    n_fail++; $display("FAIL spurious_first: got v=%b pc=%h i=%h expected 1 %h 00000013", if_valid, if_pc, if_instr, TB_RESET_PC);
                end
            end
            to_pos();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        if_ready = 1'b0;
        for (int n = 0; n < 7; n++) begin
            to_neg();
            if (n >= 2) begin
                n_checks++;
                if (if_valid !== 1'b1 || if_pc !== 32'h0 || imem_req_valid !== 1'b0) begin
                    n_fail++; $display("FAIL bp_hold cyc%0d: got v=%b pc=%h req_v=%b expected 1 0 0", n, if_valid, if_pc, imem_req_valid);
                end
            end
            to_pos();
        end
        n_checks++;
        if (acc_cnt !== 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", acc_cnt); end
        if_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            to_neg();
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'(4 * k)) begin
                n_fail++; $display("FAIL bp_drain k%0d: got v=%b pc=%h expected 1 %h", k, if_valid, if_pc, 32'(4 * k));
            end
            to_pos();
        end
    endtask

    task automatic test_redirect_held();
        logic found;
        logic req_seen;
        do_reset();
        mem_hold = 1'b1;
        to_neg(); to_pos();
        to_neg(); to_pos();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        mem_hold       = 1'b0;
        to_neg();
        n_checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
            n_fail++; $display("FAIL redir_cycle: got req_v=%b if_v=%b expected 0 0", imem_req_valid, if_valid);
        end
        to_pos();
        redirect_valid = 1'b0;
        found    = 1'b0;
        req_seen = 1'b0;
        for (int n = 0; n < 12 && !found; n++) begin
            to_neg();
            if (imem_req_valid && !req_seen) begin
                req_seen = 1'b1;
                n_checks++;
                if (imem_req_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_req_addr: got %h expected 00000100", imem_req_addr); end
            end
            if (if_valid) begin
                found = 1'b1;
                n_checks++;
                if (if_pc !== 32'h0000_0100 || if_instr !== mem_word(32'h0000_0100)) begin
                    n_fail++; $display("FAIL redir_first_pc: got pc=%h i=%h expected 00000100 %h", if_pc, if_instr, mem_word(32'h0000_0100));
                end
            end
            to_pos();
        end
        if (!found) begin
            n_checks++; n_fail++;
            $display("FAIL redir_timeout: got no if_valid expected pc 00000100");
        end
    endtask

    task automatic test_redirect_stream();
        logic found;
        do_reset();
        for (int n = 0; n < 6; n++) begin to_neg(); to_pos(); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        to_neg();
        n_checks++;
        if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir2_req: got %b expected 0", imem_req_valid); end
        to_pos();
        redirect_valid = 1'b0;
        to_neg();
        n_checks++;
        if (if_valid !== 1'b0) begin n_fail++; $display("FAIL redir2_flush: got %b expected 0", if_valid); end
        to_pos();
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            to_neg();
            if (if_valid) begin
                found = 1'b1;
                n_checks++;
                if (if_pc !== 32'h0000_0200) begin n_fail++; $display("FAIL redir2_first: got %h expected 00000200", if_pc); end
            end
            to_pos();
        end
        if (!found) begin
            n_checks++; n_fail++;
            $display("FAIL redir2_timeout: got no if_valid expected pc 00000200");
        end else begin
            to_neg();
            n_checks++;
            if (if_valid !== 1'b1 || if_pc !== 32'h0000_0204) begin
                n_fail++; $display("FAIL redir2_second: got v=%b pc=%h expected 1 00000204", if_valid, if_pc);
            end
            to_pos();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 3; n++) begin to_neg(); to_pos(); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        to_neg(); to_pos();
        redirect_valid = 1'b0;
        acc_log.delete();
        for (int n = 0; n < 6; n++) begin
            to_neg();
            if (n == 4) begin
                n_checks++;
                if (if_valid !== 1'b1 || if_pc !== 32'h0000_0000) begin
                    n_fail++; $display("FAIL wrap_if_pc: got v=%b pc=%h expected 1 00000000", if_valid, if_pc);
                end
            end
            to_pos();
        end
        n_checks++;
        if (acc_log.size() < 3) begin
            n_fail++; $display("FAIL wrap_req_count: got %0d expected at least 3", acc_log.size());
        end else if (acc_log[0] !== 32'hFFFF_FFF8 || acc_log[1] !== 32'hFFFF_FFFC || acc_log[2] !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap_req_addr: got %h %h %h expected fffffff8 fffffffc 00000000", acc_log[0], acc_log[1], acc_log[2]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int n = 0; n < 8; n++) begin
            imem_req_ready = n[0];
            to_neg(); to_pos();
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (imem_req_valid !== 1'b0 || if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0) begin
            n_fail++; $display("FAIL midrst_outputs: got req_v=%b if_v=%b i=%h pc=%h expected 0 0 0 0", imem_req_valid, if_valid, if_instr, if_pc);
        end
        to_neg(); to_pos();
        to_neg(); to_pos();
        rst            = 1'b0;
        imem_req_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            to_neg();
            n_checks++;
            if (n == 0) begin
                if (imem_req_valid !== 1'b1 || imem_req_addr !== TB_RESET_PC) begin
                    n_fail++; $display("FAIL midrst_refetch: got v=%b a=%h expected 1 %h", imem_req_valid, imem_req_addr, TB_RESET_PC);
                end
            end else if (n == 1) begin
                if (if_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_early: got %b expected 0", if_valid); end
            end else begin
                if (if_valid !== 1'b1 || if_pc !== TB_RESET_PC || if_instr !== mem_word(TB_RESET_PC)) begin
                    n_fail++; $display("FAIL midrst_first: got v=%b pc=%h i=%h expected 1 %h %h", if_valid, if_pc, if_instr, TB_RESET_PC, mem_word(TB_RESET_PC));
                end
            end
            to_pos();
        end
    endtask

`ifdef JAL_PREDECODE_EN
    task automatic test_jal();
        logic [31:0] got[$];
        do_reset();
        for (int n = 0; n < 2; n++) begin to_neg(); to_pos(); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0020;
        to_neg(); to_pos();
        redirect_valid = 1'b0;
        for (int n = 0; n < 12 && got.size() < 2; n++) begin
            to_neg();
            if (if_valid) got.push_back(if_pc);
            to_pos();
        end
        n_checks++;
        if (got.size() < 2) begin
            n_fail++; $display("FAIL jal_timeout: got %0d deliveries expected 2", got.size());
        end else if (got[0] !== 32'h0000_0020 || got[1] !== 32'h0000_0030) begin
            n_fail++; $display("FAIL jal_target: got %h %h expected 00000020 00000030", got[0], got[1]);
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        test_reset();
        test_stream();
        test_spurious_rsp();
        test_backpressure();
        test_redirect_held();
        test_redirect_stream();
        test_wrap();
        test_reset_mid();
`ifdef JAL_PREDECODE_EN
        test_jal();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
